// File: rtl/tinycomp_io_pkg.sv
// Shared definitions for the TinyComp serial I/O responder: register offsets,
// STATUS bit positions and the UART frame state encoding.
package tinycomp_io_pkg;

  localparam logic [1:0] OFS_DATA   = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;

  localparam int ST_TX_NFULL  = 0;
  localparam int ST_RX_NEMPTY = 1;
  localparam int ST_TXOVF     = 2;
  localparam int ST_RXOVR     = 3;
  localparam int ST_FERR      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  typedef struct packed {
    logic ferr;
    logic rxovr;
    logic txovf;
  } sticky_t;

  function automatic logic [31:0] status_word(sticky_t f, logic rx_nempty, logic tx_nfull);
    status_word               = '0;
    status_word[ST_FERR]      = f.ferr;
    status_word[ST_RXOVR]     = f.rxovr;
    status_word[ST_TXOVF]     = f.txovf;
    status_word[ST_RX_NEMPTY] = rx_nempty;
    status_word[ST_TX_NFULL]  = tx_nfull;
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a pop makes room for a push in the
// same cycle even when full.
module io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             Ph0,
  input  logic             Reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge Ph0 or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge Ph0) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/tinycomp_uart.sv
// TinyComp I/O-port UART: DATA/STATUS registers, TX FIFO + 8N1 serialiser,
// 2-FF synchronised 8N1 deserialiser + RX FIFO.
module tinycomp_uart
  import tinycomp_io_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'h0000_0000,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        Ph0,
  input  logic        Reset,
  input  logic [31:0] IOaddr,
  input  logic [31:0] OutData,
  input  logic        OutStrobe,
  input  logic        InStrobe,
  output logic [31:0] InData,
  output logic        InRdy,
  output logic        txd,
  input  logic        rxd
);

  localparam int            CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2 - 1);

  // ---------------- register decode ----------------
  logic       sel;
  logic [1:0] ofs;
  logic       wr_data;
  logic       rd_data;
  logic       rd_status;
  logic       unused_outdata;

  assign sel            = (IOaddr[31:2] == BASE[31:2]);
  assign ofs            = IOaddr[1:0];
  assign wr_data        = OutStrobe && sel && (ofs == OFS_DATA);
  assign rd_data        = InStrobe && sel && (ofs == OFS_DATA);
  assign rd_status      = InStrobe && sel && (ofs == OFS_STATUS);
  assign unused_outdata = ^OutData[31:8];

  // ---------------- FIFOs ----------------
  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] tx_dout;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] rx_dout;
  logic [7:0] rx_shift;

  // TX drops on full regardless of a same-cycle pop by the serialiser.
  assign tx_push = wr_data && !tx_full;
  assign rx_pop  = rd_data && !rx_empty;

  io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .Ph0   (Ph0),
    .Reset (Reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (OutData[7:0]),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty)
  );

  io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .Ph0   (Ph0),
    .Reset (Reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_shift),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // ---------------- TX serialiser ----------------
  uart_state_t   tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_shift, tx_shift_n;
  logic          txd_n;
  logic          tx_end;

  assign tx_end = (tx_cnt == CNT_LAST);

  always_ff @(posedge Ph0 or posedge Reset) begin
    if (Reset) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      txd      <= txd_n;
    end
  end

  // NOTE: combinational blocks use blocking '=' and default every output first, so no latch is inferred.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + CW'(1);
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    txd_n      = txd;
    tx_pop     = 1'b0;
    case (tx_state)
      IDLE: begin
        tx_cnt_n = '0;
        txd_n    = 1'b1;
        if (!tx_empty) begin
          tx_state_n = START;
          tx_pop     = 1'b1;
          tx_shift_n = tx_dout;
          txd_n      = 1'b0;
        end
      end
      START: begin
        if (tx_end) begin
          tx_state_n = DATA;
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          txd_n      = tx_shift[0];
        end
      end
      DATA: begin
        if (tx_end) begin
          tx_cnt_n = '0;
          if (tx_bit == 3'd7) begin
            tx_state_n = STOP;
            txd_n      = 1'b1;
          end else begin
            tx_bit_n   = tx_bit + 3'd1;
            tx_shift_n = {1'b0, tx_shift[7:1]};
            txd_n      = tx_shift[1];
          end
        end
      end
      STOP: begin
        if (tx_end) begin
          tx_cnt_n = '0;
          // Chain straight into the next start bit when more bytes are queued.
          if (!tx_empty) begin
            tx_state_n = START;
            tx_pop     = 1'b1;
            tx_shift_n = tx_dout;
            txd_n      = 1'b0;
          end else begin
            tx_state_n = IDLE;
          end
        end
      end
      default: tx_state_n = IDLE;
    endcase
  end

  // ---------------- RX deserialiser ----------------
  logic          rx_s1, rx_s2, rx_s3;
  logic          rx_fall;
  uart_state_t   rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_shift_n;
  logic          rx_done;
  logic          ferr_set;

  assign rx_fall = rx_s3 && !rx_s2;

  always_ff @(posedge Ph0 or posedge Reset) begin
    if (Reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1    <= rxd;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + CW'(1);
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_done    = 1'b0;
    ferr_set   = 1'b0;
    case (rx_state)
      IDLE: begin
        rx_cnt_n = '0;
        if (rx_fall) rx_state_n = START;
      end
      START: begin
        // Mid-start re-check rejects short glitches.
        if (rx_cnt == CNT_HALF) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s2 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s2, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_n = STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end
      end
      STOP: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_n   = '0;
          rx_state_n = IDLE;
          if (rx_s2) rx_done  = 1'b1;
          else       ferr_set = 1'b1;
        end
      end
      default: rx_state_n = IDLE;
    endcase
  end

  assign rx_push = rx_done;

  // ---------------- sticky flags ----------------
  sticky_t flags;
  logic    txovf_set;
  logic    rxovr_set;

  assign txovf_set = wr_data && tx_full;
  assign rxovr_set = rx_done && rx_full && !rx_pop;

  // A set in the same cycle as a STATUS read wins over the clear.
  always_ff @(posedge Ph0 or posedge Reset) begin
    if (Reset) begin
      flags <= '0;
    end else begin
      flags.txovf <= txovf_set || (flags.txovf && !rd_status);
      flags.rxovr <= rxovr_set || (flags.rxovr && !rd_status);
      flags.ferr  <= ferr_set  || (flags.ferr  && !rd_status);
    end
  end

  // ---------------- read mux ----------------
  always_comb begin
    InData = '0;
    InRdy  = 1'b0;
    if (sel) begin
      case (ofs)
        OFS_DATA: begin
          InData = {24'b0, rx_empty ? 8'h00 : rx_dout};
          InRdy  = !rx_empty;
        end
        OFS_STATUS: begin
          InData = status_word(flags, !rx_empty, !tx_full);
          InRdy  = 1'b1;
        end
        default: begin
          InData = '0;
          InRdy  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tinycomp_uart.sv
// Scoreboard bench for tinycomp_uart: TX frames decoded by a serial monitor,
// RX bytes checked against expectations on CPU reads, plus flag and timing checks.
module tb_tinycomp_uart;
  import tinycomp_io_pkg::*;

  localparam logic [31:0] BASE    = 32'h0000_0100;
  localparam int          CLK_DIV = 16;
  localparam int          DEPTH   = 4;

  logic        Ph0;
  logic        Reset;
  logic [31:0] IOaddr;
  logic [31:0] OutData;
  logic        OutStrobe;
  logic        InStrobe;
  logic [31:0] InData;
  logic        InRdy;
  logic        txd;
  logic        rxd;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  bit         mon_en = 1'b0;

  tinycomp_uart #(.BASE(BASE), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .Ph0       (Ph0),
    .Reset     (Reset),
    .IOaddr    (IOaddr),
    .OutData   (OutData),
    .OutStrobe (OutStrobe),
    .InStrobe  (InStrobe),
    .InData    (InData),
    .InRdy     (InRdy),
    .txd       (txd),
    .rxd       (rxd)
  );

  initial Ph0 = 1'b0;
  always #5 Ph0 = ~Ph0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge Ph0);
  endtask

  // All bus tasks start at a falling edge, so the rising edge in between is the transaction edge.
  task automatic cpu_write(input logic [1:0] ofs, input logic [7:0] b);
    IOaddr    = BASE + {30'b0, ofs};
    OutData   = {24'hDEAD_BE, b};
    OutStrobe = 1'b1;
    @(negedge Ph0);
    OutStrobe = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] ofs, output logic [31:0] d);
    IOaddr   = BASE + {30'b0, ofs};
    InStrobe = 1'b1;
    #1 d = InData;
    @(negedge Ph0);
    InStrobe = 1'b0;
  endtask

  task automatic peek(input logic [31:0] addr, output logic [31:0] d, output logic r);
    IOaddr = addr;
    #1;
    d = InData;
    r = InRdy;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    wait_cycles(CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_cycles(CLK_DIV);
    end
    rxd = stop;
    wait_cycles(CLK_DIV);
    rxd = 1'b1;
  endtask

  task automatic rx_drain_one(input string tag);
    logic [31:0] d;
    logic [7:0]  e;
    cpu_read(OFS_DATA, d);
    e = (rx_exp.size() > 0) ? rx_exp.pop_front() : ~d[7:0];
    check(tag, d, {24'b0, e});
  endtask

  // Serial monitor: decodes each TX frame at mid-bit and scores it against tx_exp.
  task automatic tx_frame();
    logic [7:0] b;
    logic [7:0] e;
    logic       st;
    wait_cycles(CLK_DIV / 2);
    check("tx_mon_start", {31'b0, txd}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      wait_cycles(CLK_DIV);
      b[i] = txd;
    end
    wait_cycles(CLK_DIV);
    st = txd;
    e  = (tx_exp.size() > 0) ? tx_exp.pop_front() : ~b;
    check("tx_mon_byte", {24'b0, b}, {24'b0, e});
    check("tx_mon_stop", {31'b0, st}, 32'd1);
  endtask

  initial begin
    forever begin
      @(negedge txd);
      if (mon_en) tx_frame();
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        r;
    logic [7:0]  a5;
    logic        ebit;
    int          j;
    int          budget;

    Reset = 1'b1; IOaddr = BASE; OutData = '0; OutStrobe = 1'b0; InStrobe = 1'b0; rxd = 1'b1;
    #1 check("rst_txd", {31'b0, txd}, 32'd1);
    wait_cycles(2);
    Reset = 1'b0;
    wait_cycles(1);
    peek(BASE + 32'd1, d, r);
    check("rst_status", d, 32'h01);
    peek(BASE, d, r);
    check("rst_rdy_data", {31'b0, r}, 32'd0);
    check("rst_data", d, 32'h0);

    // Reset mid-frame: txd returns high asynchronously and nothing resumes.
    cpu_write(OFS_DATA, 8'h5A);
    rxd = 1'b0;
    wait_cycles(8);
    check("rst_mid_txd_low", {31'b0, txd}, 32'd0);
    #2 Reset = 1'b1;
    #1 check("rst_async_txd", {31'b0, txd}, 32'd1);
    rxd = 1'b1;
    wait_cycles(2);
    Reset = 1'b0;
    wait_cycles(2);
    peek(BASE + 32'd1, d, r);
    check("rst_mid_status", d, 32'h01);
    peek(BASE, d, r);
    check("rst_mid_rdy", {31'b0, r}, 32'd0);
    wait_cycles(200);
    check("rst_mid_txd_idle", {31'b0, txd}, 32'd1);
    mon_en = 1'b1;

    // Transmit 0xA5 with exact bit timing.
    a5 = 8'hA5;
    tx_exp.push_back(a5);
    cpu_write(OFS_DATA, a5);
    check("tx_pre_start", {31'b0, txd}, 32'd1);
    for (int k = 1; k <= 10 * CLK_DIV; k++) begin
      @(negedge Ph0);
      j = (k - 1) / CLK_DIV;
      if ((k % CLK_DIV) == 1 || (k % CLK_DIV) == 0) begin
        if (j == 0)      ebit = 1'b0;
        else if (j == 9) ebit = 1'b1;
        else             ebit = a5[j-1];
        check("tx_a5_bit", {31'b0, txd}, {31'b0, ebit});
      end
    end
    @(negedge Ph0);
    check("tx_a5_idle", {31'b0, txd}, 32'd1);
    wait_cycles(5);

    // TX full: six back-to-back writes, five accepted.
    for (int i = 0; i < 6; i++) begin
      if (i < 5) tx_exp.push_back(8'h11 + 8'(i));
      cpu_write(OFS_DATA, 8'h11 + 8'(i));
    end
    cpu_read(OFS_STATUS, d);
    check("txovf_status", d, 32'h04);
    cpu_read(OFS_STATUS, d);
    check("txovf_cleared", d, 32'h00);
    budget = 0;
    while (tx_exp.size() != 0 && budget < 1500) begin
      @(negedge Ph0);
      budget++;
    end
    check("tx_drain_left", tx_exp.size(), 32'd0);
    wait_cycles(2 * CLK_DIV);
    peek(BASE + 32'd1, d, r);
    check("tx_drained_status", d, 32'h01);

    // Receive one byte.
    IOaddr = BASE;
    rx_exp.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    budget = 0;
    peek(BASE, d, r);
    while (!r && budget < 40) begin
      @(negedge Ph0);
      peek(BASE, d, r);
      budget++;
    end
    check("rx_rdy_rise", {31'b0, r}, 32'd1);
    rx_drain_one("rx_3c");
    peek(BASE, d, r);
    check("rx_rdy_fall", {31'b0, r}, 32'd0);
    cpu_read(OFS_DATA, d);
    check("rx_empty_read", d, 32'h0);

    // RX overrun: five frames, only the first four kept.
    for (int i = 0; i < 5; i++) begin
      if (i < DEPTH) rx_exp.push_back(8'h41 + 8'(i));
      send_frame(8'h41 + 8'(i), 1'b1);
    end
    wait_cycles(2);
    peek(BASE + 32'd1, d, r);
    check("rxovr_status", d, 32'h0B);
    check("status_rdy", {31'b0, r}, 32'd1);
    peek(BASE + 32'h10, d, r);
    check("unsel_data", d, 32'h0);
    check("unsel_rdy", {31'b0, r}, 32'd0);
    peek(BASE + 32'd2, d, r);
    check("ofs2_data", d, 32'h0);
    check("ofs2_rdy", {31'b0, r}, 32'd0);
    cpu_read(OFS_STATUS, d);
    check("rxovr_read", d, 32'h0B);
    peek(BASE + 32'd1, d, r);
    check("rxovr_cleared", d, 32'h03);
    for (int i = 0; i < DEPTH; i++) rx_drain_one("rxovr_byte");
    peek(BASE + 32'd1, d, r);
    check("rxovr_drained", d, 32'h01);

    // Pop on a full FIFO in the same cycle as the stop-bit sample: no overrun.
    for (int i = 0; i < DEPTH; i++) begin
      rx_exp.push_back(8'h51 + 8'(i));
      send_frame(8'h51 + 8'(i), 1'b1);
    end
    rx_exp.push_back(8'h55);
    fork
      send_frame(8'h55, 1'b1);
      begin
        wait_cycles(9 * CLK_DIV + CLK_DIV / 2 + 2);
        rx_drain_one("pof_pop");
      end
    join
    wait_cycles(2);
    peek(BASE + 32'd1, d, r);
    check("pof_status", d, 32'h03);
    for (int i = 0; i < DEPTH; i++) rx_drain_one("pof_byte");

    // Framing error: stop bit low, nothing pushed.
    send_frame(8'h66, 1'b0);
    wait_cycles(4);
    peek(BASE + 32'd1, d, r);
    check("ferr_status", d, 32'h11);
    peek(BASE, d, r);
    check("ferr_no_push", {31'b0, r}, 32'd0);
    cpu_read(OFS_STATUS, d);
    peek(BASE + 32'd1, d, r);
    check("ferr_cleared", d, 32'h01);

    // Short glitch on rxd: ignored.
    rxd = 1'b0;
    wait_cycles(3);
    rxd = 1'b1;
    wait_cycles(12 * CLK_DIV);
    peek(BASE + 32'd1, d, r);
    check("glitch_status", d, 32'h01);
    peek(BASE, d, r);
    check("glitch_no_push", {31'b0, r}, 32'd0);

    check("tx_queue_end", tx_exp.size(), 32'd0);
    check("rx_queue_end", rx_exp.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
